// File: rtl/alu_pkg.sv
// Shared ALU op / branch condition encodings and the default datapath width.
package alu_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd4,
    BR_BGE  = 3'd5,
    BR_BLTU = 3'd6,
    BR_BGEU = 3'd7
  } br_cond_e;

endpackage

// File: rtl/alu_ex_stage_if.sv
// Issue-side and result-side handshake bundle of the execute stage.
interface alu_ex_stage_if
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            in_is_branch;
  logic [2:0]      in_br_cond;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_rd;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            out_br_taken;
  logic [XLEN-1:0] out_br_target;

  // Environment side: drives operations in, consumes results.
  modport master (
    output in_valid, in_op, in_a, in_b, in_is_branch, in_br_cond, in_pc, in_imm, in_rd,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_rd, out_br_taken, out_br_target
  );

  // Stage side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_is_branch, in_br_cond, in_pc, in_imm, in_rd,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_rd, out_br_taken, out_br_target
  );

endinterface

// File: rtl/alu_ex_stage_sltu.sv
// Unsigned less-than comparator; purely combinational.
module alu_ex_stage_sltu #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);

  assign lt = (a < b);

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ALU + branch resolution into a single output register, 1-cycle latency.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds all outputs.
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  alu_ex_stage_if.slave io
);

  localparam logic [XLEN-1:0] MSB_MASK = {1'b1, {(XLEN-1){1'b0}}};

  logic            lt_u;
  logic            lt_s;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] a_flip;
  logic [XLEN-1:0] b_flip;
  logic [XLEN-1:0] alu_res;
  logic            cond_taken;
  logic            accept;

  logic [XLEN-1:0] nxt_result;
  logic [4:0]      nxt_rd;
  logic            nxt_taken;

  logic            valid_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;
  logic            taken_q;
  logic [XLEN-1:0] target_q;

  assign shamt  = io.in_b[SHW-1:0];
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_flip = io.in_a ^ MSB_MASK;
  assign b_flip = io.in_b ^ MSB_MASK;

  alu_ex_stage_sltu #(.W(XLEN)) u_sltu_unsigned (
    .a  (io.in_a),
    .b  (io.in_b),
    .lt (lt_u)
  );

  alu_ex_stage_sltu #(.W(XLEN)) u_sltu_signed (
    .a  (a_flip),
    .b  (b_flip),
    .lt (lt_s)
  );

  always_comb begin
    alu_res = '0;
    case (io.in_op)
      OP_ADD:  alu_res = io.in_a + io.in_b;
      OP_SUB:  alu_res = io.in_a - io.in_b;
      OP_AND:  alu_res = io.in_a & io.in_b;
      OP_OR:   alu_res = io.in_a | io.in_b;
      OP_XOR:  alu_res = io.in_a ^ io.in_b;
      OP_SLL:  alu_res = io.in_a << shamt;
      OP_SRL:  alu_res = io.in_a >> shamt;
      OP_SRA:  alu_res = $signed(io.in_a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    cond_taken = 1'b0;
    case (io.in_br_cond)
      BR_BEQ:  cond_taken = (io.in_a == io.in_b);
      BR_BNE:  cond_taken = (io.in_a != io.in_b);
      BR_BLT:  cond_taken = lt_s;
      BR_BGE:  cond_taken = !lt_s;
      BR_BLTU: cond_taken = lt_u;
      BR_BGEU: cond_taken = !lt_u;
      default: cond_taken = 1'b0;
    endcase
  end

  // Branches write no register, so their result and rd are zeroed here.
  always_comb begin
    nxt_result = alu_res;
    nxt_rd     = io.in_rd;
    nxt_taken  = 1'b0;
    if (io.in_is_branch) begin
      nxt_result = '0;
      nxt_rd     = '0;
      nxt_taken  = cond_taken;
    end
  end

  assign io.in_ready = !valid_q || io.out_ready;
  assign accept      = io.in_valid && io.in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      result_q <= nxt_result;
      rd_q     <= nxt_rd;
      taken_q  <= nxt_taken;
      target_q <= io.in_pc + io.in_imm;
    end else if (io.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign io.out_valid     = valid_q;
  assign io.out_result    = result_q;
  assign io.out_rd        = rd_q;
  assign io.out_br_taken  = taken_q;
  assign io.out_br_target = target_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_alu_ex_stage;
  import alu_pkg::*;

  localparam int XLEN = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  alu_ex_stage_if #(.XLEN(XLEN)) io();

  alu_ex_stage #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (io.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        taken;
    logic [63:0] target;
  } exp_t;

  function automatic exp_t ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                     input logic isbr, input logic [2:0] cond,
                                     input logic [63:0] pc, input logic [63:0] imm, input logic [4:0] rd);
    exp_t e;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    int sh;
    sa = a;
    sb = b;
    sh = int'(b[5:0]);
    e.target = pc + imm;
    e.result = 64'd0;
    e.rd     = 5'd0;
    e.taken  = 1'b0;
    if (isbr) begin
      case (cond)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = (sa < sb);
        3'd5: e.taken = !(sa < sb);
        3'd6: e.taken = (a < b);
        3'd7: e.taken = !(a < b);
        default: e.taken = 1'b0;
      endcase
    end else begin
      e.rd = rd;
      case (op)
        4'd0: e.result = a + b;
        4'd1: e.result = a - b;
        4'd2: e.result = a & b;
        4'd3: e.result = a | b;
        4'd4: e.result = a ^ b;
        4'd5: e.result = a << sh;
        4'd6: e.result = a >> sh;
        4'd7: e.result = sa >>> sh;
        4'd8: e.result = (sa < sb) ? 64'd1 : 64'd0;
        4'd9: e.result = (a < b) ? 64'd1 : 64'd0;
        default: e.result = 64'd0;
      endcase
    end
    return e;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return {64{1'b1}};
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 40));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic isbr, input logic [2:0] cond,
                       input logic [63:0] pc, input logic [63:0] imm, input logic [4:0] rd);
    io.in_valid     = 1'b1;
    io.in_op        = op;
    io.in_a         = a;
    io.in_b         = b;
    io.in_is_branch = isbr;
    io.in_br_cond   = cond;
    io.in_pc        = pc;
    io.in_imm       = imm;
    io.in_rd        = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", io.out_valid); end
    total++; if (io.out_result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h want=0", io.out_result); end
    total++; if (io.out_rd !== 5'd0 || io.out_br_taken !== 1'b0 || io.out_br_target !== 64'd0) begin
      bad++; $display("FAIL reset_fields got rd=%0d tk=%0b tgt=%h want=0", io.out_rd, io.out_br_taken, io.out_br_target);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", io.in_ready); end
    tick();
  endtask

  task automatic test_add_wrap();
    io.out_ready = 1'b1;
    drive(OP_ADD, {64{1'b1}}, 64'd1, 1'b0, 3'd0, 64'd0, 64'd0, 5'd17);
    tick();
    io.in_valid = 1'b0;
    total++; if (io.out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b want=1", io.out_valid); end
    total++; if (io.out_result !== 64'd0) begin bad++; $display("FAIL add_result got=%h want=0", io.out_result); end
    total++; if (io.out_rd !== 5'd17) begin bad++; $display("FAIL add_rd got=%0d want=17", io.out_rd); end
    tick();
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%0b want=0", io.out_valid); end
  endtask

  task automatic test_back_to_back();
    io.out_ready = 1'b1;
    drive(OP_SLTU, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 64'd0, 64'd0, 5'd1);
    tick();
    total++; if (io.out_valid !== 1'b1 || io.out_result !== 64'd0) begin
      bad++; $display("FAIL b2b_sltu got v=%0b r=%h want v=1 r=0", io.out_valid, io.out_result);
    end
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b want=1", io.in_ready); end
    drive(OP_SLT, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 64'd0, 64'd0, 5'd2);
    tick();
    io.in_valid = 1'b0;
    total++; if (io.out_valid !== 1'b1 || io.out_result !== 64'd1 || io.out_rd !== 5'd2) begin
      bad++; $display("FAIL b2b_slt got v=%0b r=%h rd=%0d want v=1 r=1 rd=2", io.out_valid, io.out_result, io.out_rd);
    end
    tick();
  endtask

  task automatic test_branch();
    io.out_ready = 1'b1;
    drive(OP_SLTU, 64'd23, 64'd23, 1'b0, 3'd0, 64'd0, 64'd0, 5'd5);
    tick();
    total++; if (io.out_result !== 64'd0) begin bad++; $display("FAIL sltu_eq got=%h want=0", io.out_result); end
    drive(OP_ADD, 64'd23, 64'd23, 1'b1, BR_BGEU, 64'h100, -64'sd8, 5'd7);
    tick();
    io.in_valid = 1'b0;
    total++; if (io.out_br_taken !== 1'b1) begin bad++; $display("FAIL bgeu_taken got=%0b want=1", io.out_br_taken); end
    total++; if (io.out_br_target !== 64'hF8) begin bad++; $display("FAIL bgeu_target got=%h want=f8", io.out_br_target); end
    total++; if (io.out_rd !== 5'd0 || io.out_result !== 64'd0) begin
      bad++; $display("FAIL bgeu_zero got rd=%0d r=%h want 0", io.out_rd, io.out_result);
    end
    tick();
  endtask

  task automatic test_stall();
    io.out_ready = 1'b0;
    drive(OP_SRA, 64'h8000_0000_0000_0000, 64'h43, 1'b0, 3'd0, 64'd0, 64'd0, 5'd9);
    tick();
    io.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (io.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%0b want=0", i, io.in_ready); end
      total++; if (io.out_valid !== 1'b1 || io.out_result !== 64'hF000_0000_0000_0000) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%0b r=%h want v=1 r=f000000000000000", i, io.out_valid, io.out_result);
      end
      tick();
    end
    io.out_ready = 1'b1;
    #1;
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%0b want=1", io.in_ready); end
    tick();
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0b want=0", io.out_valid); end
  endtask

  task automatic test_flush();
    io.out_ready = 1'b0;
    drive(OP_ADD, 64'd1, 64'd2, 1'b0, 3'd0, 64'd0, 64'd0, 5'd3);
    tick();
    total++; if (io.out_valid !== 1'b1) begin bad++; $display("FAIL flush_load got=%0b want=1", io.out_valid); end
    drive(OP_ADD, 64'd5, 64'd5, 1'b0, 3'd0, 64'd0, 64'd0, 5'd4);
    io.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    io.in_valid = 1'b0;
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL flush_kill got=%0b want=0", io.out_valid); end
    tick();
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%0b want=0", io.out_valid); end
  endtask

  task automatic test_random();
    exp_t held;
    exp_t cand;
    logic held_v;
    logic exp_rdy;
    held_v = 1'b0;
    held   = '{default: '0};
    for (int i = 0; i < 400; i++) begin
      io.in_valid     = ($urandom_range(0, 3) != 0);
      io.in_op        = 4'($urandom_range(0, 15));
      io.in_a         = pick_operand();
      io.in_b         = ($urandom_range(0, 5) == 0) ? io.in_a : pick_operand();
      io.in_is_branch = ($urandom_range(0, 3) == 0);
      io.in_br_cond   = 3'($urandom_range(0, 7));
      io.in_pc        = {$urandom, $urandom};
      io.in_imm       = {$urandom, $urandom};
      io.in_rd        = 5'($urandom_range(0, 31));
      io.out_ready    = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      exp_rdy = !held_v || io.out_ready;
      total++; if (io.in_ready !== exp_rdy) begin
        bad++; $display("FAIL rnd_ready[%0d] got=%0b want=%0b", i, io.in_ready, exp_rdy);
      end
      cand = ref_model(io.in_op, io.in_a, io.in_b, io.in_is_branch, io.in_br_cond, io.in_pc, io.in_imm, io.in_rd);
      if (flush) held_v = 1'b0;
      else if (io.in_valid && exp_rdy) begin held = cand; held_v = 1'b1; end
      else if (io.out_ready) held_v = 1'b0;
      tick();
      total++; if (io.out_valid !== held_v) begin
        bad++; $display("FAIL rnd_valid[%0d] got=%0b want=%0b", i, io.out_valid, held_v);
      end
      if (held_v) begin
        total++;
        if (io.out_result !== held.result || io.out_rd !== held.rd ||
            io.out_br_taken !== held.taken || io.out_br_target !== held.target) begin
          bad++;
          $display("FAIL rnd_data[%0d] got r=%h rd=%0d tk=%0b tgt=%h want r=%h rd=%0d tk=%0b tgt=%h", i,
                   io.out_result, io.out_rd, io.out_br_taken, io.out_br_target,
                   held.result, held.rd, held.taken, held.target);
        end
      end
    end
    flush       = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    io.out_ready = 1'b0;
    drive(OP_ADD, 64'd3, 64'd4, 1'b1, BR_BNE, 64'h40, 64'h10, 5'd9);
    tick();
    io.in_valid = 1'b0;
    total++; if (io.out_valid !== 1'b1 || io.out_br_taken !== 1'b1) begin
      bad++; $display("FAIL areset_load got v=%0b tk=%0b want 1 1", io.out_valid, io.out_br_taken);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (io.out_valid !== 1'b0 || io.out_br_taken !== 1'b0) begin
      bad++; $display("FAIL areset_clear got v=%0b tk=%0b want 0 0", io.out_valid, io.out_br_taken);
    end
    total++; if (io.out_result !== 64'd0 || io.out_rd !== 5'd0 || io.out_br_target !== 64'd0) begin
      bad++; $display("FAIL areset_fields got r=%h rd=%0d tgt=%h want 0", io.out_result, io.out_rd, io.out_br_target);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
      bad++; $display("FAIL areset_release got rdy=%0b v=%0b want 1 0", io.in_ready, io.out_valid);
    end
    tick();
  endtask

  initial begin
    io.in_valid     = 1'b0;
    io.in_op        = 4'd0;
    io.in_a         = 64'd0;
    io.in_b         = 64'd0;
    io.in_is_branch = 1'b0;
    io.in_br_cond   = 3'd0;
    io.in_pc        = 64'd0;
    io.in_imm       = 64'd0;
    io.in_rd        = 5'd0;
    io.out_ready    = 1'b0;
    test_reset();
    test_add_wrap();
    test_back_to_back();
    test_branch();
    test_stall();
    test_flush();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
